// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    // Default operand width: dividend is 2*DEF_W bits, everything else DEF_W bits.
    localparam int DEF_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must be able to hold the value W itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_W);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// try the subtract, keep it if it does not borrow, and shift the quotient bit in.
module div_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_next,
    output logic [W-1:0] q_next
);

    logic [W:0] trial;
    logic       qbit;

    // Compare at W+1 bits; the kept difference is below the divisor, so its low W bits are exact.
    always_comb begin
        trial  = {r, q[W-1]};
        qbit   = (trial >= {1'b0, divisor});
        r_next = qbit ? (trial[W-1:0] - divisor) : trial[W-1:0];
        q_next = {q[W-2:0], qbit};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider behind a start/busy/done handshake.
// Produces one quotient bit per clock; overflow and divide-by-zero finish in one cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           ovf,
    output logic           dbz
);

    localparam int CW = cnt_width(W);

    state_t        state;
    state_t        next_state;
    logic          accept;
    logic          div_zero;
    logic          too_big;
    logic [W-1:0]  r_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  div_reg;
    logic [CW-1:0] count;
    logic [W-1:0]  r_next;
    logic [W-1:0]  q_next;
    logic          last_step;

    div_step #(.W(W)) u_step (
        .r       (r_reg),
        .q       (q_reg),
        .divisor (div_reg),
        .r_next  (r_next),
        .q_next  (q_next)
    );

    // Prechecks on the raw inputs; only acted on when a start is accepted.
    always_comb begin
        div_zero  = (divisor == '0);
        too_big   = (dividend[2*W-1:W] >= divisor);
        last_step = (count == CW'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: error cases skip RUN, normal operations run W steps.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (div_zero || too_big) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers, results and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg     <= '0;
            q_reg     <= '0;
            div_reg   <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            if (accept) begin
                div_reg <= divisor;
                if (div_zero) begin
                    dbz       <= 1'b1;
                    ovf       <= 1'b1;
                    quotient  <= '1;
                    remainder <= '0;
                end else if (too_big) begin
                    dbz       <= 1'b0;
                    ovf       <= 1'b1;
                    quotient  <= '1;
                    remainder <= '0;
                end else begin
                    dbz   <= 1'b0;
                    ovf   <= 1'b0;
                    r_reg <= dividend[2*W-1:W];
                    q_reg <= dividend[W-1:0];
                    count <= CW'(W);
                end
            end else if (state == RUN) begin
                r_reg <= r_next;
                q_reg <= q_next;
                count <= count - CW'(1);
                if (last_step) begin
                    quotient  <= q_next;
                    remainder <= r_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: an arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results and timing.
module tb_seq_divider;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [2*W-1:0] dividend = '0;
   logic [W-1:0]   divisor = '0;
   logic           busy;
   logic           done;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           ovf;
   logic           dbz;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles left until idle, and the visible result registers.
   int           m_rem = 0;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_r = '0;
   logic         m_ovf = 1'b0;
   logic         m_dbz = 1'b0;
   logic [W-1:0] m_pq = '0;
   logic [W-1:0] m_pr = '0;

   seq_divider #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .dbz       (dbz)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic checkResult(input string tag, input int eq, input int er, input int eovf, input int edbz);
      checkOutput({tag, "_quotient"}, 32'(quotient), eq);
      checkOutput({tag, "_remainder"}, 32'(remainder), er);
      checkOutput({tag, "_ovf"}, 32'(ovf), eovf);
      checkOutput({tag, "_dbz"}, 32'(dbz), edbz);
   endtask

   // Model: accept only when idle; errors publish at once and finish next cycle,
   // normal operations stay busy W+1 cycles and publish a/b, a%b when done shows.
   always @(posedge clk or negedge rst_n) begin
      int a;
      int b;
      if (!rst_n) begin
         m_rem = 0;
         m_q   = '0;
         m_r   = '0;
         m_ovf = 1'b0;
         m_dbz = 1'b0;
      end else if (m_rem == 0) begin
         if (start) begin
            a = int'(dividend);
            b = int'(divisor);
            if (b == 0) begin
               m_dbz = 1'b1;
               m_ovf = 1'b1;
               m_q   = '1;
               m_r   = '0;
               m_rem = 1;
            end else if (a / b > (1 << W) - 1) begin
               m_dbz = 1'b0;
               m_ovf = 1'b1;
               m_q   = '1;
               m_r   = '0;
               m_rem = 1;
            end else begin
               m_dbz = 1'b0;
               m_ovf = 1'b0;
               m_pq  = W'(a / b);
               m_pr  = W'(a % b);
               m_rem = W + 1;
            end
         end
      end else begin
         m_rem = m_rem - 1;
         if (m_rem == 1) begin
            m_q = m_pq;
            m_r = m_pr;
         end
      end
   end

   // Every cycle, on the falling edge, the DUT must agree with the model.
   always @(negedge clk) begin
      checkOutput("cyc_busy", 32'(busy), 32'(m_rem != 0));
      checkOutput("cyc_done", 32'(done), 32'(m_rem == 1));
      checkOutput("cyc_quotient", 32'(quotient), 32'(m_q));
      checkOutput("cyc_remainder", 32'(remainder), 32'(m_r));
      checkOutput("cyc_ovf", 32'(ovf), 32'(m_ovf));
      checkOutput("cyc_dbz", 32'(dbz), 32'(m_dbz));
   end

   task automatic waitIdle();
      while (m_rem != 0) @(negedge clk);
   endtask

   // Drive a one-cycle start pulse; called and returns on a falling edge.
   task automatic applyStimulus(input logic [2*W-1:0] a, input logic [W-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // done_edge is the index of the edge that raises done, counting the accepting edge as 0.
   task automatic runDirected(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                              input int eq, input int er, input int eovf, input int edbz,
                              input int edge_idx);
      int idx;
      bit seen;
      waitIdle();
      applyStimulus(a, b);
      idx  = 0;
      seen = 1'b0;
      while (!seen && idx <= W + 3) begin
         if (done) seen = 1'b1;
         else begin
            @(negedge clk);
            idx++;
         end
      end
      checkOutput({tag, "_done_edge"}, idx, edge_idx);
      checkResult(tag, eq, er, eovf, edbz);
   endtask

   initial begin
      int nd;
      $display("[TB] starting seq_divider bench, W=%0d", W);
      repeat (2) @(negedge clk);
      checkResult("reset", 0, 0, 0, 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_done", 32'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);

      runDirected("d8F_B", 8'h8F, 4'hB, 'hD, 'h0, 0, 0, 4);
      runDirected("d64_7", 8'h64, 4'h7, 'hE, 'h2, 0, 0, 4);
      runDirected("dE1_F", 8'hE1, 4'hF, 'hF, 'h0, 0, 0, 4);
      runDirected("d12_0", 8'h12, 4'h0, 'hF, 'h0, 1, 1, 0);
      runDirected("d50_5", 8'h50, 4'h5, 'hF, 'h0, 1, 0, 0);
      runDirected("d07_3", 8'h07, 4'h3, 'h2, 'h1, 0, 0, 4);

      // Starts held through the whole run, including the done cycle, must be ignored.
      waitIdle();
      dividend = 8'h8F;
      divisor  = 4'hB;
      start    = 1'b1;
      @(negedge clk);
      nd = 0;
      for (int i = 0; i <= W; i++) begin
         if (done) nd++;
         dividend = 8'(8'h21 + 8'(i * 17));
         divisor  = 4'(3 + i);
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("ignored_done_count", nd, 1);
      checkResult("ignored", 'hD, 'h0, 0, 0);

      // Asynchronous reset in the middle of a run.
      waitIdle();
      applyStimulus(8'h64, 4'h7);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkResult("async_reset", 0, 0, 0, 0);
      checkOutput("async_reset_busy", 32'(busy), 0);
      checkOutput("async_reset_done", 32'(done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      checkOutput("post_reset_done_count", nd, 0);
      runDirected("after_reset", 8'h64, 4'h7, 'hE, 'h2, 0, 0, 4);

      // Products of two W-bit factors divide back to the other factor exactly.
      for (int a = 0; a < (1 << W); a++) begin
         for (int b = 1; b < (1 << W); b++) begin
            waitIdle();
            applyStimulus(8'(a * b), 4'(b));
            waitIdle();
            checkOutput("product_quotient", 32'(quotient), a);
            checkOutput("product_remainder", 32'(remainder), 0);
         end
      end

      // Exhaustive sweep, back-to-back; the per-cycle compare does the checking.
      for (int a = 0; a < (1 << (2 * W)); a++) begin
         for (int b = 0; b < (1 << W); b++) begin
            waitIdle();
            applyStimulus(8'(a), 4'(b));
         end
      end
      waitIdle();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
